// File: rtl/vector_pkg.sv
// Shared constants for the vector front end: opcodes, FSM encoding, vtype layout.
package vector_pkg;

  localparam logic [6:0] OPC_VL   = 7'h07;
  localparam logic [6:0] OPC_VS   = 7'h27;
  localparam logic [6:0] OPC_V    = 7'h57;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISPATCH  = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int unsigned VT_VLMUL_LSB = 0;
  localparam int unsigned VT_VLMUL_MSB = 2;
  localparam int unsigned VT_VSEW_LSB  = 3;
  localparam int unsigned VT_VSEW_MSB  = 5;
  localparam int unsigned VT_VTA       = 6;
  localparam int unsigned VT_VMA       = 7;
  localparam int unsigned VT_VILL      = 31;

  localparam logic [31:0] VTYPE_ILL = 32'h8000_0000;

  // Fields captured at acceptance and held for vector_ex until completion.
  typedef struct packed {
    logic [6:0]  op;
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic [4:0]  vs1a;
    logic [4:0]  vs2a;
    logic [4:0]  vs3a;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vinst_t;

endpackage

// File: rtl/vector_vcfg.sv
// Combinational vtype legality check, VLMAX and new vl for vset* instructions.
module vector_vcfg import vector_pkg::*; #(
  parameter int unsigned VLEN = 128
) (
  input  logic [31:0] vtype_src,
  input  logic [31:0] avl,
  input  logic [31:0] cur_vl,
  input  logic        use_vlmax,
  input  logic        keep_vl,
  output logic [31:0] vtype_new,
  output logic [31:0] vl_new
);

  localparam logic [31:0] VlenW = 32'(VLEN);

  logic        legal;
  logic [1:0]  vsew;
  logic [1:0]  vlmul;
  logic [31:0] vlmax;
  logic [31:0] avl_eff;

  always_comb begin
    legal   = (vtype_src[31:8] == '0) && !vtype_src[VT_VSEW_MSB] && !vtype_src[VT_VLMUL_MSB];
    vsew    = vtype_src[VT_VSEW_LSB +: 2];
    vlmul   = vtype_src[VT_VLMUL_LSB +: 2];
    vlmax   = (VlenW >> (3 + vsew)) << vlmul;
    avl_eff = use_vlmax ? vlmax : avl;
    if (!legal) begin
      vtype_new = VTYPE_ILL;
      vl_new    = '0;
    end else begin
      vtype_new = {24'd0, vtype_src[7:0]};
      vl_new    = keep_vl ? cur_vl : ((avl_eff < vlmax) ? avl_eff : vlmax);
    end
  end

endmodule

// File: rtl/vector_issue.sv
// Vector issue stage: runs vset* locally, dispatches vector ops to vector_ex.
// Define VISSUE_PERF_EN to add issue/stall performance counters.
module vector_issue import vector_pkg::*; #(
  parameter int unsigned VLEN = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_rd_we,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_illegal,
  output logic [6:0]  o_ops,
  output logic [5:0]  o_funct6,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  output logic [4:0]  o_vs1a,
  output logic [4:0]  o_vs2a,
  output logic [4:0]  o_vs3a,
  output logic [10:0] o_sew,
  output logic [3:0]  o_lmul,
  output logic [31:0] o_venum,
  input  logic        i_ex_busy,
`ifdef VISSUE_PERF_EN
  output logic [31:0] o_issue_cnt,
  output logic [31:0] o_stall_cnt,
`endif
  output logic [31:0] o_vl,
  output logic [31:0] o_vtype
);

  logic [1:0]  state_q, state_d;
  logic [31:0] vl_q, vtype_q;
  vinst_t      inst_q;
  logic        rd_we_q, illegal_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1a;
  logic        accept, is_vop, is_vset, vill, dispatch_go;
  logic        vset_ok, cfg_use_vlmax, cfg_keep;
  logic [31:0] cfg_vtype, cfg_avl, new_vtype, new_vl;

  assign opcode = i_inst[6:0];
  assign funct3 = i_inst[14:12];
  assign rd     = i_inst[11:7];
  assign rs1a   = i_inst[19:15];
  assign vill   = vtype_q[VT_VILL];

  assign o_ready     = (state_q == ST_IDLE);
  assign accept      = i_valid & o_ready;
  assign is_vop      = (opcode == OPC_VL) || (opcode == OPC_VS) || (opcode == OPC_V);
  assign is_vset     = (opcode == OPC_V) && (funct3 == F3_OPCFG);
  assign dispatch_go = accept && is_vop && !is_vset && !vill && (vl_q != '0);

  // vset* variant decode; the 10xxxxx form other than vsetvl is reserved.
  always_comb begin
    vset_ok       = 1'b1;
    cfg_vtype     = '0;
    cfg_avl       = i_rs1;
    cfg_use_vlmax = 1'b0;
    cfg_keep      = 1'b0;
    if (i_inst[31:30] == 2'b11) begin
      cfg_vtype = {22'd0, i_inst[29:20]};
      cfg_avl   = {27'd0, rs1a};
    end else begin
      if (!i_inst[31]) begin
        cfg_vtype = {21'd0, i_inst[30:20]};
      end else if (i_inst[31:25] == 7'b1000000) begin
        cfg_vtype = i_rs2;
      end else begin
        vset_ok = 1'b0;
      end
      cfg_use_vlmax = (rs1a == 5'd0) && (rd != 5'd0);
      cfg_keep      = (rs1a == 5'd0) && (rd == 5'd0);
    end
  end

  vector_vcfg #(
    .VLEN(VLEN)
  ) u_vcfg (
    .vtype_src (cfg_vtype),
    .avl       (cfg_avl),
    .cur_vl    (vl_q),
    .use_vlmax (cfg_use_vlmax),
    .keep_vl   (cfg_keep),
    .vtype_new (new_vtype),
    .vl_new    (new_vl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (dispatch_go) state_d = ST_DISPATCH;
      ST_DISPATCH:  if (!i_ex_busy) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (i_ex_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!i_ex_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vl_q      <= '0;
      vtype_q   <= VTYPE_ILL;
      inst_q    <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      illegal_q <= 1'b0;
      if (accept) begin
        if (is_vset) begin
          if (vset_ok) begin
            vl_q    <= new_vl;
            vtype_q <= new_vtype;
            if (rd != 5'd0) begin
              rd_we_q   <= 1'b1;
              rd_addr_q <= rd;
              rd_data_q <= new_vl;
            end
          end else begin
            illegal_q <= 1'b1;
          end
        end else if (!is_vop || vill) begin
          illegal_q <= 1'b1;
        end else if (dispatch_go) begin
          inst_q <= '{op: opcode, funct6: i_inst[31:26], funct3: funct3, vs1a: rs1a,
                      vs2a: i_inst[24:20], vs3a: rd, rs1: i_rs1, rs2: i_rs2};
        end
      end
    end
  end

`ifdef VISSUE_PERF_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (o_ops != 7'd0) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (i_valid && !o_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_issue_cnt = issue_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

  assign o_ops     = (state_q == ST_DISPATCH && !i_ex_busy) ? inst_q.op : 7'd0;
  assign o_funct6  = inst_q.funct6;
  assign o_funct3  = inst_q.funct3;
  assign o_rs1     = inst_q.rs1;
  assign o_rs2     = inst_q.rs2;
  assign o_vs1a    = inst_q.vs1a;
  assign o_vs2a    = inst_q.vs2a;
  assign o_vs3a    = inst_q.vs3a;
  assign o_rd_we   = rd_we_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_illegal = illegal_q;
  // vill reads as zero width/grouping so the reset state presents all-zero outputs.
  assign o_sew     = vill ? 11'd0 : (11'd8 << vtype_q[VT_VSEW_LSB +: 2]);
  assign o_lmul    = vill ? 4'd0 : 4'((4'd1 << vtype_q[VT_VLMUL_LSB +: 2]) - 4'd1);
  assign o_venum   = vl_q;
  assign o_vl      = vl_q;
  assign o_vtype   = vtype_q;

endmodule

// File: tb/tb_vector_issue.sv
// Directed self-checking bench for vector_issue with VLEN = 128.
module tb_vector_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_inst, i_rs1, i_rs2;
  logic        o_rd_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_illegal;
  logic [6:0]  o_ops;
  logic [5:0]  o_funct6;
  logic [2:0]  o_funct3;
  logic [31:0] o_rs1, o_rs2;
  logic [4:0]  o_vs1a, o_vs2a, o_vs3a;
  logic [10:0] o_sew;
  logic [3:0]  o_lmul;
  logic [31:0] o_venum;
  logic        i_ex_busy;
  logic [31:0] o_vl, o_vtype;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_issue #(
    .VLEN(128)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_inst    (i_inst),
    .i_rs1     (i_rs1),
    .i_rs2     (i_rs2),
    .o_rd_we   (o_rd_we),
    .o_rd_addr (o_rd_addr),
    .o_rd_data (o_rd_data),
    .o_illegal (o_illegal),
    .o_ops     (o_ops),
    .o_funct6  (o_funct6),
    .o_funct3  (o_funct3),
    .o_rs1     (o_rs1),
    .o_rs2     (o_rs2),
    .o_vs1a    (o_vs1a),
    .o_vs2a    (o_vs2a),
    .o_vs3a    (o_vs3a),
    .o_sew     (o_sew),
    .o_lmul    (o_lmul),
    .o_venum   (o_venum),
    .i_ex_busy (i_ex_busy),
    .o_vl      (o_vl),
    .o_vtype   (o_vtype)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                           input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  // Offer one instruction for a single accepting edge, then withdraw it.
  task automatic issue(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    i_inst  = inst;
    i_rs1   = rs1;
    i_rs2   = rs2;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  localparam logic [31:0] VADD  = {6'b0, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3, 7'h57};
  localparam logic [31:0] VLE32 = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd10, 3'b110, 5'd4, 7'h07};
  localparam logic [31:0] VSETVL = {7'b1000000, 5'd6, 5'd5, 3'b111, 5'd4, 7'h57};

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_inst = '0; i_rs1 = '0; i_rs2 = '0; i_ex_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_vl", o_vl, 32'd0);
    chk("reset_vtype", o_vtype, 32'h8000_0000);
    chk("reset_ops", 32'(o_ops), 32'd0);
    chk("reset_sew", 32'(o_sew), 32'd0);
    chk("reset_illegal", 32'(o_illegal), 32'd0);
    chk("reset_rd_we", 32'(o_rd_we), 32'd0);

    // vsetvli x1, x5, e32,m1 with AVL 10 -> VLMAX 4
    issue(vsetvli(5'd1, 5'd5, 11'h010), 32'd10, 32'd0);
    chk("e32m1_rd_we", 32'(o_rd_we), 32'd1);
    chk("e32m1_rd_addr", 32'(o_rd_addr), 32'd1);
    chk("e32m1_rd_data", o_rd_data, 32'd4);
    chk("e32m1_vl", o_vl, 32'd4);
    chk("e32m1_venum", o_venum, 32'd4);
    chk("e32m1_sew", 32'(o_sew), 32'd32);
    chk("e32m1_lmul", 32'(o_lmul), 32'd0);
    chk("e32m1_vtype", o_vtype, 32'h10);
    tick();
    chk("rd_we_pulse_end", 32'(o_rd_we), 32'd0);

    // e8,m8 with AVL 200 -> VLMAX 128
    issue(vsetvli(5'd2, 5'd6, 11'h003), 32'd200, 32'd0);
    chk("e8m8_vl", o_vl, 32'd128);
    chk("e8m8_rd_data", o_rd_data, 32'd128);
    chk("e8m8_lmul", 32'(o_lmul), 32'd7);
    chk("e8m8_sew", 32'(o_sew), 32'd8);

    // vsetivli x3, 5, e16,m2 -> vl 5
    issue(vsetivli(5'd3, 5'd5, 10'h009), 32'hFFFF_FFFF, 32'd0);
    chk("ivli_vl", o_vl, 32'd5);
    chk("ivli_rd_addr", 32'(o_rd_addr), 32'd3);
    chk("ivli_sew", 32'(o_sew), 32'd16);
    chk("ivli_lmul", 32'(o_lmul), 32'd1);

    // rs1 = x0, rd = x0: vtype changes to e8,m1, vl kept, no rd write
    issue(vsetvli(5'd0, 5'd0, 11'h000), 32'd99, 32'd0);
    chk("keep_vl", o_vl, 32'd5);
    chk("keep_vtype", o_vtype, 32'h0);
    chk("keep_no_rd_we", 32'(o_rd_we), 32'd0);

    // rs1 = x0, rd != x0: AVL = VLMAX (e16,m1 -> 8)
    issue(vsetvli(5'd7, 5'd0, 11'h008), 32'd1, 32'd0);
    chk("vlmax_vl", o_vl, 32'd8);
    chk("vlmax_rd_data", o_rd_data, 32'd8);
    chk("vlmax_rd_addr", 32'(o_rd_addr), 32'd7);

    // vsetvl x4, x5, x6 with e64,m2 from rs2, AVL 100 -> VLMAX 4
    issue(VSETVL, 32'd100, 32'h19);
    chk("vsetvl_vl", o_vl, 32'd4);
    chk("vsetvl_sew", 32'(o_sew), 32'd64);
    chk("vsetvl_lmul", 32'(o_lmul), 32'd1);
    chk("vsetvl_rd_addr", 32'(o_rd_addr), 32'd4);

    // Reserved vlmul -> vill, vl 0, rd still written
    issue(vsetvli(5'd1, 5'd5, 11'h005), 32'd10, 32'd0);
    chk("ill_vtype", o_vtype, 32'h8000_0000);
    chk("ill_vl", o_vl, 32'd0);
    chk("ill_rd_we", 32'(o_rd_we), 32'd1);
    chk("ill_rd_data", o_rd_data, 32'd0);
    chk("ill_sew", 32'(o_sew), 32'd0);
    issue(VADD, 32'd1, 32'd2);
    chk("vill_vadd_illegal", 32'(o_illegal), 32'd1);
    chk("vill_vadd_ops", 32'(o_ops), 32'd0);
    chk("vill_vadd_ready", 32'(o_ready), 32'd1);
    tick();
    chk("illegal_pulse_end", 32'(o_illegal), 32'd0);

    // Non-vector opcode is dropped as illegal
    issue(32'h0000_0013, 32'd0, 32'd0);
    chk("scalar_op_illegal", 32'(o_illegal), 32'd1);
    chk("scalar_op_ready", 32'(o_ready), 32'd1);

    // Legal vtype with AVL 0 -> vl 0; a vector op then retires silently
    issue(vsetvli(5'd1, 5'd5, 11'h010), 32'd0, 32'd0);
    chk("avl0_vl", o_vl, 32'd0);
    issue(VADD, 32'd1, 32'd2);
    chk("vl0_ready", 32'(o_ready), 32'd1);
    chk("vl0_illegal", 32'(o_illegal), 32'd0);
    chk("vl0_ops", 32'(o_ops), 32'd0);

    // vadd with vl 4; busy rises 1 cycle after the pulse and lasts 3 cycles
    issue(vsetvli(5'd1, 5'd5, 11'h010), 32'd10, 32'd0);
    issue(VADD, 32'hDEAD_BEEF, 32'h1234_5678);
    chk("vadd_ops_pulse", 32'(o_ops), 32'h57);
    chk("vadd_ready_low", 32'(o_ready), 32'd0);
    chk("vadd_vs1a", 32'(o_vs1a), 32'd1);
    chk("vadd_vs2a", 32'(o_vs2a), 32'd2);
    chk("vadd_vs3a", 32'(o_vs3a), 32'd3);
    chk("vadd_rs1", o_rs1, 32'hDEAD_BEEF);
    chk("vadd_rs2", o_rs2, 32'h1234_5678);
    tick();
    chk("vadd_ops_once", 32'(o_ops), 32'd0);
    i_ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("vadd_busy_ops", 32'(o_ops), 32'd0);
      chk("vadd_busy_ready", 32'(o_ready), 32'd0);
    end
    chk("vadd_hold_vs1a", 32'(o_vs1a), 32'd1);
    chk("vadd_hold_venum", o_venum, 32'd4);
    i_ex_busy = 1'b0;
    #1;
    chk("vadd_ready_same_cycle", 32'(o_ready), 32'd0);
    tick();
    chk("vadd_ready_back", 32'(o_ready), 32'd1);

    // Load dispatched with vector_ex already busy for 5 cycles
    i_ex_busy = 1'b1;
    issue(VLE32, 32'h1000, 32'd0);
    chk("vle_held_ops_0", 32'(o_ops), 32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("vle_held_ops", 32'(o_ops), 32'd0);
      chk("vle_held_ready", 32'(o_ready), 32'd0);
    end
    i_ex_busy = 1'b0;
    #1;
    chk("vle_ops_pulse", 32'(o_ops), 32'h07);
    chk("vle_funct3", 32'(o_funct3), 32'd6);
    chk("vle_vs3a", 32'(o_vs3a), 32'd4);
    chk("vle_rs1", o_rs1, 32'h1000);
    tick();
    chk("vle_ops_once", 32'(o_ops), 32'd0);
    i_ex_busy = 1'b1;
    tick();
    chk("vle_wait_done_ready", 32'(o_ready), 32'd0);

    // Reset while in WAIT_DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_ex_busy = 1'b0;
    chk("rst_wd_ready", 32'(o_ready), 32'd1);
    chk("rst_wd_vl", o_vl, 32'd0);
    chk("rst_wd_vtype", o_vtype, 32'h8000_0000);
    chk("rst_wd_ops", 32'(o_ops), 32'd0);
    tick();
    chk("rst_wd_idle_stays", 32'(o_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
